// File: rtl/tankb_video_pkg.sv
// Shared video timing constants and fetch phase encodings for the Tank B
// background tile pipeline.
package tankb_video_pkg;

  localparam int H_TOTAL   = 384;
  localparam int H_VISIBLE = 256;
  localparam int HS_START  = 304;
  localparam int HS_WIDTH  = 32;
  localparam int V_TOTAL   = 264;
  localparam int V_VISIBLE = 224;
  localparam int VS_START  = 240;
  localparam int VS_WIDTH  = 4;

  // Pixel phase within an 8-pixel group at which each fetch step happens.
  typedef enum logic [2:0] {
    PH_VADDR = 3'd0,
    PH_CODE  = 3'd2,
    PH_CADDR = 3'd3,
    PH_ROW   = 3'd5,
    PH_LOAD  = 3'd7
  } fetch_phase_e;

endpackage

// File: rtl/tankb_raster_cnt.sv
// Horizontal/vertical raster counters with blank, sync and frame-start decode.
// The next-count values are exported so the fetch sequencer can decode
// the phase that becomes current on this pixel enable.
module tankb_raster_cnt
  import tankb_video_pkg::*;
#(
  parameter int H_TOTAL_P   = H_TOTAL,
  parameter int H_VISIBLE_P = H_VISIBLE,
  parameter int HS_START_P  = HS_START,
  parameter int HS_WIDTH_P  = HS_WIDTH,
  parameter int V_TOTAL_P   = V_TOTAL,
  parameter int V_VISIBLE_P = V_VISIBLE,
  parameter int VS_START_P  = VS_START,
  parameter int VS_WIDTH_P  = VS_WIDTH
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pix_ce_i,
  output logic [8:0] hcnt_o,
  output logic [8:0] vcnt_o,
  output logic [8:0] hcnt_next_o,
  output logic [8:0] vcnt_next_o,
  output logic       hblank_o,
  output logic       vblank_o,
  output logic       n_hsync_o,
  output logic       n_vsync_o,
  output logic       frame_start_o
);

  logic [8:0] hcnt_q, hcnt_d;
  logic [8:0] vcnt_q, vcnt_d;
  logic       hblank_q, vblank_q, nHsync_q, nVsync_q, frameStart_q;

  // Next raster position: hcnt wraps at the line end and carries into vcnt.
  always_comb begin
    if (hcnt_q == 9'(H_TOTAL_P - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == 9'(V_TOTAL_P - 1)) ? '0 : vcnt_q + 9'd1;
    end else begin
      hcnt_d = hcnt_q + 9'd1;
      vcnt_d = vcnt_q;
    end
  end

  // Advance the counters and register every decode from the new position so it lines up with the counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      hblank_q     <= 1'b0;
      vblank_q     <= 1'b0;
      nHsync_q     <= 1'b1;
      nVsync_q     <= 1'b1;
      frameStart_q <= 1'b0;
    end else if (pix_ce_i) begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      hblank_q     <= (hcnt_d >= 9'(H_VISIBLE_P));
      vblank_q     <= (vcnt_d >= 9'(V_VISIBLE_P));
      nHsync_q     <= !((hcnt_d >= 9'(HS_START_P)) && (hcnt_d < 9'(HS_START_P + HS_WIDTH_P)));
      nVsync_q     <= !((vcnt_d >= 9'(VS_START_P)) && (vcnt_d < 9'(VS_START_P + VS_WIDTH_P)));
      frameStart_q <= (hcnt_d == '0) && (vcnt_d == '0);
    end
  end

  assign hcnt_o        = hcnt_q;
  assign vcnt_o        = vcnt_q;
  assign hcnt_next_o   = hcnt_d;
  assign vcnt_next_o   = vcnt_d;
  assign hblank_o      = hblank_q;
  assign vblank_o      = vblank_q;
  assign n_hsync_o     = nHsync_q;
  assign n_vsync_o     = nVsync_q;
  assign frame_start_o = frameStart_q;

endmodule

// File: rtl/tankb_tile_fetch.sv
// Background tile fetch sequencer: walks VRAM and the character ROM one
// 8-pixel group ahead of the beam and presents each bitmap row to the ls166.
module tankb_tile_fetch
  import tankb_video_pkg::*;
#(
  parameter int H_TOTAL_P   = H_TOTAL,
  parameter int H_VISIBLE_P = H_VISIBLE,
  parameter int HS_START_P  = HS_START,
  parameter int HS_WIDTH_P  = HS_WIDTH,
  parameter int V_TOTAL_P   = V_TOTAL,
  parameter int V_VISIBLE_P = V_VISIBLE,
  parameter int VS_START_P  = VS_START,
  parameter int VS_WIDTH_P  = VS_WIDTH
) (
  input  logic        clk,
  input  logic        n_clr,
  input  logic        pix_ce,
  output logic [9:0]  vram_addr,
  input  logic [7:0]  vram_data,
  output logic [10:0] crom_addr,
  input  logic [7:0]  crom_data,
  output logic [7:0]  shift_data,
  output logic        n_load,
  output logic [8:0]  hcnt,
  output logic [8:0]  vcnt,
  output logic        hblank,
  output logic        vblank,
  output logic        n_hsync,
  output logic        n_vsync,
  output logic        frame_start
);

  logic [8:0]  hcnt_d, vcnt_d;
  logic [5:0]  nxCol;
  logic [8:0]  nyRow;
  logic        nextVisible;
  logic [9:0]  vramAddr_q;
  logic [10:0] cromAddr_q;
  logic [7:0]  tileCode_q, rowBits_q, shiftData_q;
  logic        nLoad_q;

  tankb_raster_cnt #(
    .H_TOTAL_P   (H_TOTAL_P),
    .H_VISIBLE_P (H_VISIBLE_P),
    .HS_START_P  (HS_START_P),
    .HS_WIDTH_P  (HS_WIDTH_P),
    .V_TOTAL_P   (V_TOTAL_P),
    .V_VISIBLE_P (V_VISIBLE_P),
    .VS_START_P  (VS_START_P),
    .VS_WIDTH_P  (VS_WIDTH_P)
  ) u_raster (
    .clk_i         (clk),
    .rst_ni        (n_clr),
    .pix_ce_i      (pix_ce),
    .hcnt_o        (hcnt),
    .vcnt_o        (vcnt),
    .hcnt_next_o   (hcnt_d),
    .vcnt_next_o   (vcnt_d),
    .hblank_o      (hblank),
    .vblank_o      (vblank),
    .n_hsync_o     (n_hsync),
    .n_vsync_o     (n_vsync),
    .frame_start_o (frame_start)
  );

  // Column/row of the group being prefetched: one group ahead, rolling into the next line at the end of this one.
  always_comb begin
    nxCol = (hcnt_d[8:3] == 6'(H_TOTAL_P / 8 - 1)) ? '0 : hcnt_d[8:3] + 6'd1;
    if (nxCol == '0) begin
      nyRow = (vcnt_d == 9'(V_TOTAL_P - 1)) ? '0 : vcnt_d + 9'd1;
    end else begin
      nyRow = vcnt_d;
    end
    nextVisible = (nxCol < 6'(H_VISIBLE_P / 8)) && (nyRow < 9'(V_VISIBLE_P));
  end

  // Phase-sequenced fetch; the phase is the pixel position this enable moves the beam onto, so n_load is low while hcnt[2:0]==7.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      vramAddr_q  <= '0;
      cromAddr_q  <= '0;
      tileCode_q  <= '0;
      rowBits_q   <= '0;
      shiftData_q <= '0;
      nLoad_q     <= 1'b1;
    end else if (pix_ce) begin
      case (hcnt_d[2:0])
        PH_VADDR: vramAddr_q  <= {nyRow[7:3], nxCol[4:0]};
        PH_CODE:  tileCode_q  <= vram_data;
        PH_CADDR: cromAddr_q  <= {tileCode_q, nyRow[2:0]};
        PH_ROW:   rowBits_q   <= crom_data;
        PH_LOAD:  shiftData_q <= nextVisible ? rowBits_q : 8'h00;
        default:  ;
      endcase
      nLoad_q <= (hcnt_d[2:0] != PH_LOAD);
    end
  end

  assign vram_addr  = vramAddr_q;
  assign crom_addr  = cromAddr_q;
  assign shift_data = shiftData_q;
  assign n_load     = nLoad_q;

endmodule

// File: tb/tb_tankb_tile_fetch.sv
// Self-checking bench for tankb_tile_fetch: random VRAM/ROM contents and
// random pixel enables compared against a raster/tile model. The vertical
// timing is shortened so several frames fit in a short run.
module tb_tankb_tile_fetch;

  localparam int H_TOTAL   = 384;
  localparam int H_VISIBLE = 256;
  localparam int HS_START  = 304;
  localparam int HS_WIDTH  = 32;
  localparam int V_TOTAL   = 40;
  localparam int V_VISIBLE = 24;
  localparam int VS_START  = 30;
  localparam int VS_WIDTH  = 4;
  localparam int LIMIT     = 2 * H_TOTAL * V_TOTAL;

  logic        clk = 1'b0;
  logic        n_clr = 1'b1;
  logic        pix_ce = 1'b0;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_data;
  logic [10:0] crom_addr;
  logic [7:0]  crom_data;
  logic [7:0]  shift_data;
  logic        n_load;
  logic [8:0]  hcnt, vcnt;
  logic        hblank, vblank, n_hsync, n_vsync, frame_start;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] vramMem [1024];
  logic [7:0] romMem [2048];

  // Free-running system clock.
  always #5 clk = ~clk;

  tankb_tile_fetch #(
    .H_TOTAL_P(H_TOTAL), .H_VISIBLE_P(H_VISIBLE), .HS_START_P(HS_START), .HS_WIDTH_P(HS_WIDTH),
    .V_TOTAL_P(V_TOTAL), .V_VISIBLE_P(V_VISIBLE), .VS_START_P(VS_START), .VS_WIDTH_P(VS_WIDTH)
  ) dut (
    .clk(clk), .n_clr(n_clr), .pix_ce(pix_ce),
    .vram_addr(vram_addr), .vram_data(vram_data),
    .crom_addr(crom_addr), .crom_data(crom_data),
    .shift_data(shift_data), .n_load(n_load),
    .hcnt(hcnt), .vcnt(vcnt), .hblank(hblank), .vblank(vblank),
    .n_hsync(n_hsync), .n_vsync(n_vsync), .frame_start(frame_start)
  );

  // Synchronous tile RAM and character ROM, both clocked by the pixel enable.
  always @(posedge clk) begin
    if (pix_ce) begin
      vram_data <= vramMem[vram_addr];
      crom_data <= romMem[crom_addr];
    end
  end

  // Reference model: beam position plus what the shifter should be given for the group one ahead of the beam.
  int   mh, mv;
  bit   fetchOk, caKnown, sdKnown, expFs, expNload;
  logic [9:0]  expVa;
  logic [10:0] expCa;
  logic [7:0]  expSd;

  always @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      mh = 0; mv = 0; fetchOk = 0;
      expVa = '0; expCa = '0; expSd = '0;
      caKnown = 1; sdKnown = 1; expFs = 0; expNload = 1;
    end else if (pix_ce) begin
      int nx, ny, tile;
      mh = mh + 1;
      if (mh == H_TOTAL) begin
        mh = 0;
        mv = (mv + 1) % V_TOTAL;
      end
      nx = ((mh / 8) * 8 + 8) % H_TOTAL;
      ny = (nx == 0) ? (mv + 1) % V_TOTAL : mv;
      tile = ((ny / 8) % 32) * 32 + (nx / 8) % 32;
      expFs = (mh == 0 && mv == 0);
      expNload = (mh % 8 != 7);
      if (mh % 8 == 0) begin
        fetchOk = 1;
        expVa = 10'(tile);
      end
      if (mh % 8 == 3) begin
        expCa = 11'(vramMem[tile] * 8 + ny % 8);
        caKnown = fetchOk;
      end
      if (mh % 8 == 7) begin
        if (nx < H_VISIBLE && ny < V_VISIBLE) begin
          expSd = romMem[vramMem[tile] * 8 + ny % 8];
          sdKnown = fetchOk;
        end else begin
          expSd = 8'h00;
          sdKnown = 1;
        end
      end
    end
  end

  task automatic cyc(input logic ce);
    @(negedge clk);
    pix_ce = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int h, input int v, output bit reached);
    int guard = 0;
    while (!(hcnt === 9'(h) && vcnt === 9'(v)) && guard < LIMIT) begin
      cyc(1'b1);
      guard++;
    end
    reached = (hcnt === 9'(h) && vcnt === 9'(v));
  endtask

  task automatic test_reset();
    pix_ce = 1'b1;
    #2 n_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({hcnt, vcnt} !== 18'd0) begin
      mismatched++; $display("[TB] FAIL reset_counts: got h=%0d v=%0d expected 0/0", hcnt, vcnt);
    end
    compared++;
    if ({hblank, vblank, n_hsync, n_vsync, n_load, frame_start} !== 6'b001110) begin
      mismatched++; $display("[TB] FAIL reset_flags: got %b expected 001110", {hblank, vblank, n_hsync, n_vsync, n_load, frame_start});
    end
    compared++;
    if ({vram_addr, crom_addr, shift_data} !== 29'd0) begin
      mismatched++; $display("[TB] FAIL reset_data: got va=%h ca=%h sd=%h expected 0", vram_addr, crom_addr, shift_data);
    end
  endtask

  task automatic test_frame_timing();
    int fsCount = 0, hsLow = 0, firstHsLow = -1, vsLines = 0, lastH0 = -1, hPeriod = 0, vWrapAt = -1;
    logic prevVs = 1'b1;
    logic [8:0] prevV = '0;
    @(negedge clk);
    n_clr = 1'b1;
    pix_ce = 1'b0;
    for (int i = 1; i <= H_TOTAL * V_TOTAL + H_TOTAL; i++) begin
      cyc(1'b1);
      compared++;
      if ({hcnt, vcnt} !== {9'(mh), 9'(mv)}) begin
        mismatched++; $display("[TB] FAIL raster_count: got h=%0d v=%0d expected h=%0d v=%0d", hcnt, vcnt, mh, mv);
      end
      compared++;
      if ({hblank, vblank} !== {mh >= H_VISIBLE, mv >= V_VISIBLE}) begin
        mismatched++; $display("[TB] FAIL blank_decode at h=%0d v=%0d: got %b%b", mh, mv, hblank, vblank);
      end
      compared++;
      if ({n_hsync, n_vsync} !== {!(mh >= HS_START && mh < HS_START + HS_WIDTH), !(mv >= VS_START && mv < VS_START + VS_WIDTH)}) begin
        mismatched++; $display("[TB] FAIL sync_decode at h=%0d v=%0d: got %b%b", mh, mv, n_hsync, n_vsync);
      end
      compared++;
      if (frame_start !== (mh == 0 && mv == 0)) begin
        mismatched++; $display("[TB] FAIL frame_start at h=%0d v=%0d: got %b", mh, mv, frame_start);
      end
      if (i <= H_TOTAL * V_TOTAL && frame_start === 1'b1) fsCount++;
      if (hcnt === 9'd0) begin
        if (lastH0 >= 0) hPeriod = i - lastH0;
        lastH0 = i;
      end
      if (vcnt === 9'd0 && prevV === 9'(V_TOTAL - 1)) vWrapAt = i;
      prevV = vcnt;
      if (i < H_TOTAL && n_hsync === 1'b0) begin
        hsLow++;
        if (firstHsLow < 0) firstHsLow = i;
      end
      if (n_vsync !== prevVs) begin
        compared++;
        if (hcnt !== 9'd0) begin
          mismatched++; $display("[TB] FAIL vsync_edge_h: got hcnt=%0d expected 0", hcnt);
        end
        compared++;
        if (vcnt !== 9'(n_vsync ? VS_START + VS_WIDTH : VS_START)) begin
          mismatched++; $display("[TB] FAIL vsync_edge_v: got vcnt=%0d", vcnt);
        end
      end
      prevVs = n_vsync;
      if (i <= H_TOTAL * V_TOTAL && hcnt === 9'd0 && n_vsync === 1'b0) vsLines++;
    end
    compared++;
    if (fsCount != 1) begin
      mismatched++; $display("[TB] FAIL frame_start_count: got %0d expected 1", fsCount);
    end
    compared++;
    if (hPeriod != H_TOTAL) begin
      mismatched++; $display("[TB] FAIL hcnt_period: got %0d expected %0d", hPeriod, H_TOTAL);
    end
    compared++;
    if (vWrapAt != H_TOTAL * V_TOTAL) begin
      mismatched++; $display("[TB] FAIL vcnt_period: got %0d expected %0d", vWrapAt, H_TOTAL * V_TOTAL);
    end
    compared++;
    if (hsLow != HS_WIDTH || firstHsLow != HS_START) begin
      mismatched++; $display("[TB] FAIL hsync_width: got %0d from %0d expected %0d from %0d", hsLow, firstHsLow, HS_WIDTH, HS_START);
    end
    compared++;
    if (vsLines != VS_WIDTH) begin
      mismatched++; $display("[TB] FAIL vsync_lines: got %0d expected %0d", vsLines, VS_WIDTH);
    end
  endtask

  task automatic test_line_wrap();
    bit reached;
    run_until(376, 7, reached);
    compared++;
    if (!reached) begin
      mismatched++; $display("[TB] FAIL line_wrap_reach: got h=%0d v=%0d expected 376/7", hcnt, vcnt);
    end else begin
      compared++;
      if (vram_addr !== {5'd1, 5'd0}) begin
        mismatched++; $display("[TB] FAIL line_wrap_vaddr: got %h expected %h", vram_addr, {5'd1, 5'd0});
      end
      repeat (3) cyc(1'b1);
      compared++;
      if (crom_addr !== {vramMem[32], 3'd0}) begin
        mismatched++; $display("[TB] FAIL line_wrap_caddr: got %h expected %h", crom_addr, {vramMem[32], 3'd0});
      end
      repeat (4) cyc(1'b1);
      compared++;
      if ({n_load, shift_data} !== {1'b0, romMem[{vramMem[32], 3'd0}]}) begin
        mismatched++; $display("[TB] FAIL line_wrap_load: got %b/%h expected 0/%h", n_load, shift_data, romMem[{vramMem[32], 3'd0}]);
      end
    end
  endtask

  task automatic test_freeze_reset();
    bit reached;
    run_until(100, 20, reached);
    compared++;
    if (!reached) begin
      mismatched++; $display("[TB] FAIL freeze_reach: got h=%0d v=%0d expected 100/20", hcnt, vcnt);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0);
      compared++;
      if ({hcnt, vcnt} !== {9'd100, 9'd20}) begin
        mismatched++; $display("[TB] FAIL freeze_count: got h=%0d v=%0d expected 100/20", hcnt, vcnt);
      end
      compared++;
      if ({vram_addr, crom_addr, shift_data, n_load} !== {expVa, expCa, expSd, expNload}) begin
        mismatched++; $display("[TB] FAIL freeze_fetch: got %h/%h/%h/%b expected %h/%h/%h/%b",
                               vram_addr, crom_addr, shift_data, n_load, expVa, expCa, expSd, expNload);
      end
    end
    @(posedge clk);
    #3 n_clr = 1'b0;
    #1;
    compared++;
    if ({hcnt, vcnt, vram_addr, crom_addr, shift_data} !== 47'd0 ||
        {hblank, vblank, n_hsync, n_vsync, n_load, frame_start} !== 6'b001110) begin
      mismatched++; $display("[TB] FAIL async_reset: got h=%0d v=%0d va=%h ca=%h sd=%h n_load=%b", hcnt, vcnt, vram_addr, crom_addr, shift_data, n_load);
    end
    repeat (2) cyc(1'b1);
    @(negedge clk);
    n_clr = 1'b1;
    pix_ce = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      cyc(1'b1);
      compared++;
      if ({hcnt, vcnt, n_load} !== {9'(j % H_TOTAL), 9'd0, (j != 7)}) begin
        mismatched++; $display("[TB] FAIL restart_load step %0d: got h=%0d v=%0d n_load=%b", j, hcnt, vcnt, n_load);
      end
    end
  endtask

  task automatic test_blank();
    bit reached;
    run_until(247, 0, reached);
    compared++;
    if (!reached || shift_data !== romMem[{vramMem[31], 3'd0}]) begin
      mismatched++; $display("[TB] FAIL last_visible_col: got %h expected %h", shift_data, romMem[{vramMem[31], 3'd0}]);
    end
    run_until(255, 0, reached);
    compared++;
    if (!reached || {n_load, shift_data} !== 9'd0) begin
      mismatched++; $display("[TB] FAIL hblank_load: got %b/%h expected 0/00", n_load, shift_data);
    end
    run_until(7, V_VISIBLE, reached);
    compared++;
    if (!reached || {n_load, shift_data} !== 9'd0) begin
      mismatched++; $display("[TB] FAIL vblank_load: got %b/%h expected 0/00", n_load, shift_data);
    end
    run_until(H_TOTAL - 1, V_TOTAL - 1, reached);
    compared++;
    if (!reached || {n_load, shift_data} !== {1'b0, romMem[{vramMem[0], 3'd0}]}) begin
      mismatched++; $display("[TB] FAIL frame_wrap_load: got %b/%h expected 0/%h", n_load, shift_data, romMem[{vramMem[0], 3'd0}]);
    end
  endtask

  task automatic test_fetch_random();
    for (int i = 0; i < 16000; i++) begin
      cyc($urandom_range(3, 0) != 0);
      compared++;
      if ({hcnt, vcnt, frame_start, n_load} !== {9'(mh), 9'(mv), expFs, expNload}) begin
        mismatched++; $display("[TB] FAIL rand_timing: got h=%0d v=%0d fs=%b nl=%b expected h=%0d v=%0d fs=%b nl=%b",
                               hcnt, vcnt, frame_start, n_load, mh, mv, expFs, expNload);
      end
      compared++;
      if (vram_addr !== expVa) begin
        mismatched++; $display("[TB] FAIL rand_vaddr at h=%0d v=%0d: got %h expected %h", mh, mv, vram_addr, expVa);
      end
      if (caKnown) begin
        compared++;
        if (crom_addr !== expCa) begin
          mismatched++; $display("[TB] FAIL rand_caddr at h=%0d v=%0d: got %h expected %h", mh, mv, crom_addr, expCa);
        end
      end
      if (sdKnown) begin
        compared++;
        if (shift_data !== expSd) begin
          mismatched++; $display("[TB] FAIL rand_shift at h=%0d v=%0d: got %h expected %h", mh, mv, shift_data, expSd);
        end
      end
    end
  endtask

  // Test sequence: fill the memories, then walk each scenario in turn.
  initial begin
    for (int i = 0; i < 1024; i++) vramMem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) romMem[i] = 8'($urandom);
    test_reset();
    test_frame_timing();
    test_line_wrap();
    test_freeze_reset();
    test_blank();
    test_fetch_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
